// File: rtl/thread_ctrl_pkg.sv
// Shared types and constants for the per-thread pipeline controller.
package thread_ctrl_pkg;

    localparam int NUM_Threads          = 4;
    localparam int FLUSH_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } thread_ctrl_state_e;

    // The counter only has to hold FLUSH_CYCLES-1, but it never shrinks below one bit.
    function automatic int cnt_width(int flush_cycles);
        return (flush_cycles > 0) ? $clog2(flush_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/thread_ctrl_if.sv
// Request/response bundle between the execute/hazard logic and the thread controller.
interface thread_ctrl_if #(
    parameter int NUM_THREADS = thread_ctrl_pkg::NUM_Threads,
    parameter int XLEN        = 32
);

    logic [NUM_THREADS-1:0]           hold_req;
    logic [NUM_THREADS-1:0]           jump_req;
    logic [NUM_THREADS-1:0][XLEN-1:0] jump_addr_req;
    logic [NUM_THREADS-1:0]           halt_req;
    logic [NUM_THREADS-1:0]           resume_req;

    logic [NUM_THREADS-1:0]           hold;
    logic [NUM_THREADS-1:0]           flush;
    logic [NUM_THREADS-1:0]           jump_en;
    logic [NUM_THREADS-1:0][XLEN-1:0] jump_addr;
    logic [NUM_THREADS-1:0]           halted;
    logic                             all_halted;

    modport master (
        output hold_req, jump_req, jump_addr_req, halt_req, resume_req,
        input  hold, flush, jump_en, jump_addr, halted, all_halted
    );

    modport slave (
        input  hold_req, jump_req, jump_addr_req, halt_req, resume_req,
        output hold, flush, jump_en, jump_addr, halted, all_halted
    );

endinterface

// File: rtl/thread_ctrl_fsm.sv
// One hardware thread: RUN/FLUSH/HALT state machine, flush-window counter and
// the combinational hold/flush/jump outputs derived from it.
module thread_ctrl_fsm
    import thread_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_req,
    input  logic            jump_req,
    input  logic [XLEN-1:0] jump_addr_req,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            hold,
    output logic            flush,
    output logic            jump_en,
    output logic [XLEN-1:0] jump_addr,
    output logic            halted
);

    localparam int              CNT_W      = cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    thread_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halt_pend_q, halt_pend_d;
    logic               jacc;

    assign jacc = jump_req && (state_q != HALT);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            RUN: begin
                if (jacc && (FLUSH_CYCLES > 0)) begin
                    state_d     = FLUSH;
                    cnt_d       = CNT_RELOAD;
                    halt_pend_d = halt_req;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            FLUSH: begin
                if (jacc) begin
                    // A newer jump restarts the window; a pending halt survives it.
                    cnt_d       = CNT_RELOAD;
                    halt_pend_d = halt_pend_q | halt_req;
                end else if (cnt_q == '0) begin
                    state_d     = (halt_pend_q | halt_req) ? HALT : RUN;
                    halt_pend_d = 1'b0;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    halt_pend_d = halt_pend_q | halt_req;
                end
            end
            HALT: begin
                if (resume_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        jump_en   = jacc;
        jump_addr = jump_addr_req;
        hold      = hold_req | jacc | halt_req | (state_q != RUN);
        flush     = jacc | (state_q == FLUSH);
        halted    = (state_q == HALT);
    end

endmodule

// File: rtl/thread_ctrl.sv
// Registered hold/flush/jump controller for all hardware threads; each thread
// runs its own independent FSM and only all_halted combines them.
module thread_ctrl
    import thread_ctrl_pkg::*;
#(
    parameter int NUM_THREADS  = NUM_Threads,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    thread_ctrl_if.slave bus
);

    logic [NUM_THREADS-1:0]           hold_w;
    logic [NUM_THREADS-1:0]           flush_w;
    logic [NUM_THREADS-1:0]           jump_en_w;
    logic [NUM_THREADS-1:0][XLEN-1:0] jump_addr_w;
    logic [NUM_THREADS-1:0]           halted_w;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        thread_ctrl_fsm #(
            .XLEN         (XLEN),
            .FLUSH_CYCLES (FLUSH_CYCLES)
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .hold_req      (bus.hold_req[t]),
            .jump_req      (bus.jump_req[t]),
            .jump_addr_req (bus.jump_addr_req[t]),
            .halt_req      (bus.halt_req[t]),
            .resume_req    (bus.resume_req[t]),
            .hold          (hold_w[t]),
            .flush         (flush_w[t]),
            .jump_en       (jump_en_w[t]),
            .jump_addr     (jump_addr_w[t]),
            .halted        (halted_w[t])
        );
    end

    assign bus.hold       = hold_w;
    assign bus.flush      = flush_w;
    assign bus.jump_en    = jump_en_w;
    assign bus.jump_addr  = jump_addr_w;
    assign bus.halted     = halted_w;
    assign bus.all_halted = &halted_w;

endmodule

// File: doc/thread_ctrl.md
Name: thread_ctrl

Overview:
- Per-thread pipeline control unit for the multi-thread core. It replaces the purely combinational hold/jump merge with a registered per-thread controller.
- Merges stage hold requests and jump requests, as before, and adds:
  - a multi-cycle flush window after each jump;
  - per-thread debug halt/resume.
- Sits between the execute/hazard logic (request side) and the IF/ID/EX pipeline registers (hold/flush side) for all hardware threads.

Parameters:
- NUM_THREADS, default NUM_Threads (types package): number of hardware threads.
- XLEN, default 32: jump address width.
- FLUSH_CYCLES, default 2: cycles of hold+flush after the jump cycle. 0 is legal.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- hold_req[NUM_THREADS]  in  1 each  stage hold request per thread
- jump_req[NUM_THREADS]  in  1 each  jump/branch-taken request per thread
- jump_addr_req[NUM_THREADS]  in  XLEN each  jump target per thread
- halt_req[NUM_THREADS]  in  1 each  debug halt request (level or pulse)
- resume_req[NUM_THREADS]  in  1 each  debug resume request
- hold[NUM_THREADS]  out  1 each  freeze PC/IF for thread
- flush[NUM_THREADS]  out  1 each  invalidate in-flight instructions of thread
- jump_en[NUM_THREADS]  out  1 each  accepted jump, load PC
- jump_addr[NUM_THREADS]  out  XLEN each  PC load value
- halted[NUM_THREADS]  out  1 each  thread is in HALT state
- all_halted  out  1  AND of halted[]

Behaviour:
- One clock domain. Reset is asynchronous, active-high; all state elements clear on rst assertion.
- Threads are fully independent; no cross-thread interaction except all_halted.
- Per-thread FSM states: RUN, FLUSH, HALT. Reset state is RUN, cnt=0, halt_pend=0.
- Jump acceptance: jacc[t] = jump_req[t] && state!=HALT.
- Outputs, all combinational, same-cycle from state and requests:
  - jump_en[t] = jacc[t]
  - jump_addr[t] = jump_addr_req[t] (pass-through, always)
  - hold[t] = hold_req[t] | jacc[t] | halt_req[t] | (state!=RUN)
  - flush[t] = jacc[t] | (state==FLUSH)
  - halted[t] = (state==HALT)
- Reset values, with inputs 0 under rst: hold=0, flush=0, jump_en=0, halted=0, all_halted=0 (NUM_THREADS≥1).
- RUN transitions:
  - jacc and FLUSH_CYCLES>0 -> FLUSH, cnt=FLUSH_CYCLES-1.
  - jacc and FLUSH_CYCLES==0 -> stay RUN.
  - halt_req -> HALT. If jacc occurs in the same cycle, the jump is taken and halt_pend is set.
    - FLUSH_CYCLES>0: go to FLUSH first, then HALT.
    - FLUSH_CYCLES==0: HALT immediately.
- FLUSH transitions:
  - Each cycle, cnt decrements.
  - A new jacc restarts the window: cnt=FLUSH_CYCLES-1 (newest jump wins).
  - halt_req sets halt_pend.
  - When cnt==0 and there is no new jacc: -> HALT if halt_pend|halt_req, else -> RUN. halt_pend clears on leaving FLUSH.
- HALT transitions:
  - jump_req ignored (jump_en=0); hold=1, flush=0.
  - resume_req -> RUN next cycle; resume wins over a simultaneous halt_req.
  - resume_req in RUN or FLUSH is ignored.
- Flush window: hold/flush are asserted in the jump cycle plus exactly FLUSH_CYCLES following cycles.
- Counter width: $clog2(FLUSH_CYCLES+1), minimum 1. Wrap-around is impossible by construction.
- hold_req never changes state; it only ORs into hold.
- Reset mid-FLUSH or mid-HALT returns the thread to RUN immediately (asynchronous); the pending flush is discarded.

Decomposition:
- types package additions:
  - thread_ctrl_state_e enum {RUN, FLUSH, HALT};
  - FLUSH_CYCLES_DEFAULT constant.
- NUM_Threads is reused from the same package.
- Sub-module thread_ctrl_fsm: one thread's FSM, counter and output logic. thread_ctrl instantiates it NUM_THREADS times in a generate loop and forms all_halted.

Test Plan:
- Reset: assert rst for 3 cycles with random inputs held 0 -> all outputs 0, all threads RUN. Assert rst asynchronously mid-cycle -> outputs drop without waiting for a clock edge.
- Jump flush window: FLUSH_CYCLES=2, thread 1 jump_req pulse at cycle 10 with addr 0x0000_0200 -> jump_en[1]=1 and jump_addr[1]=0x200 at cycle 10 only; hold[1]=flush[1]=1 at cycles 10, 11, 12; both 0 at cycle 13; threads 0, 2, 3 unaffected.
- Back-to-back jumps: thread 0 jumps at cycles 5 and 6 (addr 0x100, 0x180) -> jump_en high both cycles; flush held through cycle 8; RUN at 9.
- Halt during flush: thread 2 jump at cycle 20, halt_req pulse at cycle 21 -> flush through cycle 22; halted[2]=1 from cycle 23. A jump_req at cycle 25 gives jump_en[2]=0. resume_req at cycle 30 -> halted[2]=0 and hold[2]=0 at cycle 31.
- Simultaneous halt and resume: in HALT, both asserted -> RUN next cycle. In RUN, both asserted -> HALT next cycle. Halt all 4 threads -> all_halted=1; resume one -> all_halted=0.
- FLUSH_CYCLES=0 build: jump at cycle 4 -> hold/flush high at cycle 4 only, state stays RUN. hold_req alone at cycle 7 -> hold=1, flush=0, state unchanged.
